// File: rtl/sn_width_adapter_pkg.sv
// -----------------------------------------------------------------------------
// sn_width_adapter_pkg
// Shared helpers for the snooper datapath blocks:
//   sn_clog2     - ceiling log2, usable in constant (parameter) expressions
//   sn_byte_cnt  - converts a narrow-word valid-byte count at a given lane into
//                  the valid-byte count of the wide word, modulo the wide-word
//                  byte count (0 = all bytes valid)
// -----------------------------------------------------------------------------
package sn_width_adapter_pkg;

   function automatic int sn_clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < value) r = r + 1;
      end
      return r;
   endfunction

   // A narrow count of 0 means the whole narrow word is valid. The result wraps
   // so that a completely full wide word is reported as 0.
   function automatic int sn_byte_cnt(input int lane,
                                      input int inc,
                                      input int in_bytes,
                                      input int out_bytes);
      int nb;
      nb = (inc == 0) ? in_bytes : inc;
      return (lane * in_bytes + nb) % out_bytes;
   endfunction

endpackage

// File: rtl/sn_width_adapter.sv
// -----------------------------------------------------------------------------
// sn_width_adapter
// Packs narrow snooper writes (IN_WIDTH) into wide packet-memory writes
// (OUT_WIDTH), big-endian: lane 0 lands in the MSBs of the wide word. A wide
// write is emitted one cycle after the last lane is written or on in_done,
// whichever comes first. All outputs are registered; there is no back-pressure.
//
// Ports
//   clk          in   sole clock, rising edge
//   rst          in   asynchronous active-high reset
//   in_addr      in   snooper word address (upper bits = wide word, low = lane)
//   in_wr_data   in   snooper data word, byte 0 in MSBs
//   in_wr_en     in   in_wr_data valid
//   in_byte_inc  in   valid bytes in the narrow word (0 = all)
//   in_done      in   end-of-packet pulse
//   out_addr     out  packet-memory word address
//   out_wr_data  out  assembled wide word
//   out_wr_en    out  single-cycle write strobe
//   out_byte_inc out  valid bytes in the wide word (0 = all)
//   out_done     out  end-of-packet pulse, one cycle after in_done
// -----------------------------------------------------------------------------
module sn_width_adapter
   import sn_width_adapter_pkg::*;
#(
   parameter int OUT_WIDTH      = 64,
   parameter int IN_WIDTH       = 32,
   parameter int OUT_ADDR_WIDTH = 9,
   parameter int IN_ADDR_WIDTH  = 10,
   localparam int OUT_INC_WIDTH = sn_clog2(OUT_WIDTH / 8),
   localparam int IN_INC_WIDTH  = sn_clog2(IN_WIDTH / 8)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [IN_ADDR_WIDTH-1:0]  in_addr,
   input  logic [IN_WIDTH-1:0]       in_wr_data,
   input  logic                      in_wr_en,
   input  logic [IN_INC_WIDTH-1:0]   in_byte_inc,
   input  logic                      in_done,
   output logic [OUT_ADDR_WIDTH-1:0] out_addr,
   output logic [OUT_WIDTH-1:0]      out_wr_data,
   output logic                      out_wr_en,
   output logic [OUT_INC_WIDTH-1:0]  out_byte_inc,
   output logic                      out_done
);

   localparam int R          = OUT_WIDTH / IN_WIDTH;
   localparam int LANE_W     = sn_clog2(R);
   localparam int LANE_SEL_W = (LANE_W > 0) ? LANE_W : 1;
   localparam int IN_BYTES   = IN_WIDTH / 8;
   localparam int OUT_BYTES  = OUT_WIDTH / 8;

   logic [LANE_SEL_W-1:0]     lane;
   logic [OUT_ADDR_WIDTH-1:0] word;

   // With R=1 there is no lane field and the address passes straight through.
   generate
      if (LANE_W == 0) begin : g_pass
         assign lane = '0;
         assign word = in_addr;
      end else begin : g_lanes
         assign lane = in_addr[LANE_W-1:0];
         assign word = in_addr[IN_ADDR_WIDTH-1:LANE_W];
      end
   endgenerate

   // Partial-word holding state: data, owning wide address and the byte count
   // of the most recently written lane (used if in_done arrives on its own).
   logic [OUT_WIDTH-1:0]      hold_p0;
   logic                      pend_p0;
   logic [OUT_ADDR_WIDTH-1:0] pend_addr_p0;
   logic [OUT_INC_WIDTH-1:0]  pend_cnt_p0;

   logic [OUT_WIDTH-1:0]      merged;
   logic [OUT_INC_WIDTH-1:0]  wr_cnt;
   logic                      lane_last;

   always_comb begin
      // Lane 0 starts a fresh word, so stale lanes are dropped rather than merged.
      merged = (lane == '0) ? '0 : hold_p0;
      for (int l = 0; l < R; l++) begin
         if (int'(lane) == l) merged[OUT_WIDTH-1-l*IN_WIDTH -: IN_WIDTH] = in_wr_data;
      end
      wr_cnt    = OUT_INC_WIDTH'(sn_byte_cnt(int'(lane), int'(in_byte_inc), IN_BYTES, OUT_BYTES));
      lane_last = (int'(lane) == R - 1);
   end

   // ---- stage boundary: input -> registered output ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_p0      <= '0;
         pend_p0      <= 1'b0;
         pend_addr_p0 <= '0;
         pend_cnt_p0  <= '0;
         out_addr     <= '0;
         out_wr_data  <= '0;
         out_wr_en    <= 1'b0;
         out_byte_inc <= '0;
         out_done     <= 1'b0;
      end else begin
         out_wr_en <= 1'b0;
         out_done  <= in_done;
         if (in_wr_en) begin
            if (lane_last || in_done) begin
               out_wr_en    <= 1'b1;
               out_addr     <= word;
               out_wr_data  <= merged;
               out_byte_inc <= wr_cnt;
               hold_p0      <= '0;
               pend_p0      <= 1'b0;
            end else begin
               hold_p0      <= merged;
               pend_p0      <= 1'b1;
               pend_addr_p0 <= word;
               pend_cnt_p0  <= wr_cnt;
            end
         end else if (in_done && pend_p0) begin
            out_wr_en    <= 1'b1;
            out_addr     <= pend_addr_p0;
            out_wr_data  <= hold_p0;
            out_byte_inc <= pend_cnt_p0;
            hold_p0      <= '0;
            pend_p0      <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sn_width_adapter.sv
module tb_sn_width_adapter;

   logic        clk;
   logic        rst;

   // 32 -> 64 instance
   logic [9:0]  in_addr;
   logic [31:0] in_wr_data;
   logic        in_wr_en;
   logic [1:0]  in_byte_inc;
   logic        in_done;
   logic [8:0]  out_addr;
   logic [63:0] out_wr_data;
   logic        out_wr_en;
   logic [2:0]  out_byte_inc;
   logic        out_done;

   // 64 -> 64 passthrough instance
   logic [8:0]  p_in_addr;
   logic [63:0] p_in_wr_data;
   logic        p_in_wr_en;
   logic [2:0]  p_in_byte_inc;
   logic        p_in_done;
   logic [8:0]  p_out_addr;
   logic [63:0] p_out_wr_data;
   logic        p_out_wr_en;
   logic [2:0]  p_out_byte_inc;
   logic        p_out_done;

   int total;
   int bad;

   sn_width_adapter #(
      .OUT_WIDTH(64), .IN_WIDTH(32), .OUT_ADDR_WIDTH(9), .IN_ADDR_WIDTH(10)
   ) dut (
      .clk(clk), .rst(rst),
      .in_addr(in_addr), .in_wr_data(in_wr_data), .in_wr_en(in_wr_en),
      .in_byte_inc(in_byte_inc), .in_done(in_done),
      .out_addr(out_addr), .out_wr_data(out_wr_data), .out_wr_en(out_wr_en),
      .out_byte_inc(out_byte_inc), .out_done(out_done)
   );

   sn_width_adapter #(
      .OUT_WIDTH(64), .IN_WIDTH(64), .OUT_ADDR_WIDTH(9), .IN_ADDR_WIDTH(9)
   ) dut_pass (
      .clk(clk), .rst(rst),
      .in_addr(p_in_addr), .in_wr_data(p_in_wr_data), .in_wr_en(p_in_wr_en),
      .in_byte_inc(p_in_byte_inc), .in_done(p_in_done),
      .out_addr(p_out_addr), .out_wr_data(p_out_wr_data), .out_wr_en(p_out_wr_en),
      .out_byte_inc(p_out_byte_inc), .out_done(p_out_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total = total + 1;
      if (obs !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [1:0] inc, input logic dn);
      in_addr     = a;
      in_wr_data  = d;
      in_wr_en    = 1'b1;
      in_byte_inc = inc;
      in_done     = dn;
      step();
      in_wr_en    = 1'b0;
      in_done     = 1'b0;
   endtask

   task automatic done_only();
      in_wr_en = 1'b0;
      in_done  = 1'b1;
      step();
      in_done  = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst = 1'b1;
      in_addr = '0; in_wr_data = '0; in_wr_en = 1'b0; in_byte_inc = '0; in_done = 1'b0;
      p_in_addr = '0; p_in_wr_data = '0; p_in_wr_en = 1'b0; p_in_byte_inc = '0; p_in_done = 1'b0;
      step();
      step();
      check_val("rst_addr", 64'(out_addr), 64'h0);
      check_val("rst_data", out_wr_data, 64'h0);
      check_val("rst_en", 64'(out_wr_en), 64'h0);
      check_val("rst_inc", 64'(out_byte_inc), 64'h0);
      check_val("rst_done", 64'(out_done), 64'h0);
      rst = 1'b0;
      step();

      // Full word from two lanes
      wr(10'd0, 32'hAABBCCDD, 2'd0, 1'b0);
      check_val("pair_lane0_no_en", 64'(out_wr_en), 64'h0);
      wr(10'd1, 32'h11223344, 2'd0, 1'b0);
      check_val("pair_en", 64'(out_wr_en), 64'h1);
      check_val("pair_addr", 64'(out_addr), 64'h0);
      check_val("pair_data", out_wr_data, 64'hAABBCCDD11223344);
      check_val("pair_inc", 64'(out_byte_inc), 64'h0);
      check_val("pair_done", 64'(out_done), 64'h0);
      step();
      check_val("pair_en_pulse", 64'(out_wr_en), 64'h0);

      // Last lane partial with in_done
      wr(10'd2, 32'h01020304, 2'd0, 1'b0);
      wr(10'd3, 32'h05060000, 2'd2, 1'b1);
      check_val("tail_en", 64'(out_wr_en), 64'h1);
      check_val("tail_addr", 64'(out_addr), 64'h1);
      check_val("tail_data", out_wr_data, 64'h0102030405060000);
      check_val("tail_inc", 64'(out_byte_inc), 64'h6);
      check_val("tail_done", 64'(out_done), 64'h1);
      step();
      check_val("tail_done_pulse", 64'(out_done), 64'h0);
      check_val("tail_en_pulse", 64'(out_wr_en), 64'h0);

      // Lane-0 single byte with in_done
      wr(10'd4, 32'hDEADBEEF, 2'd1, 1'b1);
      check_val("l0done_en", 64'(out_wr_en), 64'h1);
      check_val("l0done_addr", 64'(out_addr), 64'h2);
      check_val("l0done_data", out_wr_data, 64'hDEADBEEF00000000);
      check_val("l0done_inc", 64'(out_byte_inc), 64'h1);
      check_val("l0done_done", 64'(out_done), 64'h1);

      // Lane-0 full word with in_done: 4 valid bytes
      wr(10'd14, 32'h0BADCAFE, 2'd0, 1'b1);
      check_val("l0full_addr", 64'(out_addr), 64'h7);
      check_val("l0full_data", out_wr_data, 64'h0BADCAFE00000000);
      check_val("l0full_inc", 64'(out_byte_inc), 64'h4);

      // in_done with nothing pending
      done_only();
      check_val("idle_done", 64'(out_done), 64'h1);
      check_val("idle_done_en", 64'(out_wr_en), 64'h0);

      // Pending partial word flushed by a standalone in_done
      wr(10'd6, 32'hCAFEF00D, 2'd3, 1'b0);
      check_val("pend_no_en", 64'(out_wr_en), 64'h0);
      done_only();
      check_val("flush_en", 64'(out_wr_en), 64'h1);
      check_val("flush_addr", 64'(out_addr), 64'h3);
      check_val("flush_data", out_wr_data, 64'hCAFEF00D00000000);
      check_val("flush_inc", 64'(out_byte_inc), 64'h3);
      check_val("flush_done", 64'(out_done), 64'h1);
      done_only();
      check_val("flush_emptied", 64'(out_wr_en), 64'h0);

      // Asynchronous reset with a partial word pending
      wr(10'd10, 32'h77777777, 2'd0, 1'b0);
      wr(10'd11, 32'h88888888, 2'd0, 1'b0);
      wr(10'd12, 32'h66666666, 2'd0, 1'b0);
      check_val("pre_rst_addr", 64'(out_addr), 64'h5);
      rst = 1'b1;
      #1;
      check_val("arst_addr", 64'(out_addr), 64'h0);
      check_val("arst_data", out_wr_data, 64'h0);
      check_val("arst_en", 64'(out_wr_en), 64'h0);
      check_val("arst_inc", 64'(out_byte_inc), 64'h0);
      step();
      rst = 1'b0;
      done_only();
      check_val("arst_discard_en", 64'(out_wr_en), 64'h0);
      check_val("arst_discard_done", 64'(out_done), 64'h1);
      wr(10'd0, 32'h13579BDF, 2'd0, 1'b0);
      wr(10'd1, 32'h2468ACE0, 2'd0, 1'b0);
      check_val("post_rst_en", 64'(out_wr_en), 64'h1);
      check_val("post_rst_data", out_wr_data, 64'h13579BDF2468ACE0);

      // 64 -> 64 passthrough
      p_in_addr = 9'h1A5; p_in_wr_data = 64'h0123456789ABCDEF;
      p_in_wr_en = 1'b1; p_in_byte_inc = 3'd5; p_in_done = 1'b0;
      step();
      p_in_wr_en = 1'b0;
      check_val("pass_en", 64'(p_out_wr_en), 64'h1);
      check_val("pass_addr", 64'(p_out_addr), 64'h1A5);
      check_val("pass_data", p_out_wr_data, 64'h0123456789ABCDEF);
      check_val("pass_inc", 64'(p_out_byte_inc), 64'h5);
      p_in_addr = 9'h0F0; p_in_wr_data = 64'hFEDCBA9876543210;
      p_in_wr_en = 1'b1; p_in_byte_inc = 3'd0; p_in_done = 1'b1;
      step();
      p_in_wr_en = 1'b0; p_in_done = 1'b0;
      check_val("pass2_addr", 64'(p_out_addr), 64'h0F0);
      check_val("pass2_data", p_out_wr_data, 64'hFEDCBA9876543210);
      check_val("pass2_inc", 64'(p_out_byte_inc), 64'h0);
      check_val("pass2_done", 64'(p_out_done), 64'h1);
      step();
      check_val("pass_en_pulse", 64'(p_out_wr_en), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
